// File: rtl/instr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_sequencer                                                 |
// | Brief    : Steps through a small program memory and presents each word to  |
// |            simple_cpu for EXEC_CYCLES clocks. Optional SEQ_SINGLE_STEP_EN  |
// |            adds a step input that gates advance past the last hold cycle.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_sequencer #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 5,
  parameter int EXEC_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                      step,
`endif
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_waddr,
  input  logic [INSTR_WIDTH-1:0]    prog_wdata,
  output logic [INSTR_WIDTH-1:0]    instr_out,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_fetch = 2'd1;
  localparam logic [1:0] c_hold  = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  localparam int                        c_depth     = 2 ** PROG_ADDR_BITS;
  localparam logic [3:0]                c_last_cnt  = 4'(EXEC_CYCLES - 1);
  localparam logic [PROG_ADDR_BITS-1:0] c_last_addr = '1;

  logic [INSTR_WIDTH-1:0]    r_mem [c_depth];
  logic [1:0]                r_state;
  logic [3:0]                r_cnt;
  logic [PROG_ADDR_BITS-1:0] r_pc;
  logic [INSTR_WIDTH-1:0]    r_instr;

  logic [INSTR_WIDTH-1:0]    w_fetch_word;
  logic                      w_fetch_halt;
  logic                      w_hold_last;
  logic                      w_advance;
  logic                      w_mem_we;

  assign w_fetch_word = r_mem[r_pc];
  assign w_fetch_halt = (w_fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00);
  assign w_hold_last  = (r_cnt == c_last_cnt);

`ifdef SEQ_SINGLE_STEP_EN
  assign w_advance = w_hold_last & step;
`else
  assign w_advance = w_hold_last;
`endif

  // The program may only be changed while no run is in flight.
  assign w_mem_we = prog_we && ((r_state == c_idle) || (r_state == c_done));

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[prog_waddr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (abort) begin
      r_state <= c_idle;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_state <= c_fetch;
            r_pc    <= '0;
          end
        end
        c_fetch: begin
          r_cnt <= '0;
          // A HALT word is never issued, so instr_out keeps the previous word.
          if (w_fetch_halt) begin
            r_state <= c_done;
          end else begin
            r_state <= c_hold;
            r_instr <= w_fetch_word;
          end
        end
        c_hold: begin
          if (w_advance) begin
            r_pc    <= r_pc + 1'b1;
            r_state <= (r_pc == c_last_addr) ? c_done : c_fetch;
          end else if (!w_hold_last) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign instr_out   = r_instr;
  assign instr_valid = (r_state == c_hold);
  assign pc          = r_pc;
  assign busy        = (r_state == c_fetch) || (r_state == c_hold);
  assign done        = (r_state == c_done);

endmodule
`default_nettype wire
